// File: rtl/multi_writer_pkg.sv
// Shared definitions for the multi-writer register: mode encodings and the
// wrap-around first-set-bit search used by the arbiter.
package multi_writer_pkg;

   localparam logic [1:0] MODE_PRIO = 2'd0;
   localparam logic [1:0] MODE_RR   = 2'd1;
   localparam logic [1:0] MODE_AND  = 2'd2;
   localparam logic [1:0] MODE_OR   = 2'd3;

   localparam int unsigned MAX_SRC = 32;
   localparam int unsigned IDX_W   = 5;

   // Index of the first set bit among vec[n-1:0], searching upward from start
   // and wrapping to 0. Returns 0 when no bit is set; callers gate on |vec.
   function automatic int unsigned first_set_from(input logic [MAX_SRC-1:0] vec,
                                                  input int unsigned n,
                                                  input int unsigned start);
      int unsigned idx;
      logic        found;
      first_set_from = 0;
      found          = 1'b0;
      for (int unsigned k = 0; k < MAX_SRC; k++) begin
         if (k < n && !found) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (vec[idx[IDX_W-1:0]]) begin
               found          = 1'b1;
               first_set_from = idx;
            end
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning the rotating pointer; with use_ptr low it searches
// from index 0 and so acts as a fixed-priority arbiter.
module rr_arbiter
   import multi_writer_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         use_ptr,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [MAX_SRC-1:0] req_ext;
   int unsigned        start;
   int unsigned        win;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      start          = use_ptr ? 32'(ptr_q) : 32'd0;
      win            = first_set_from(req_ext, N, start);
      gnt            = '0;
      for (int unsigned i = 0; i < N; i++) begin
         gnt[i] = (|req) && (win == i);
      end
      ptr_d = ptr_q;
      if (advance && (|req)) begin
         ptr_d = (win == N - 1) ? '0 : PTR_W'(win + 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/multi_writer_reg.sv
// Shared register written by N_SRC sources with run-time selectable conflict
// resolution, broadcast override and collision statistics.
module multi_writer_reg
   import multi_writer_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned N_SRC = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             mode,
   input  logic [N_SRC-1:0]       wr_valid,
   input  logic [N_SRC*WIDTH-1:0] wr_data,
   output logic [N_SRC-1:0]       wr_ready,
   input  logic                   bcast_en,
   input  logic                   bcast_val,
   input  logic                   clr_stat,
   output logic [WIDTH-1:0]       q,
   output logic [CNT_W-1:0]       conflict_cnt,
   output logic                   conflict_sticky
);

   logic [N_SRC-1:0] gnt;
   logic             rr_mode;
   logic             collision;
   logic [WIDTH-1:0] sel_data, and_data, or_data;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q;
   logic             sticky_q;

   assign rr_mode   = (mode == MODE_RR);
   assign collision = ($countones(wr_valid) > 1);

   // Broadcast cycles must not rotate the pointer.
   rr_arbiter #(
      .N (N_SRC)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (wr_valid),
      .use_ptr (rr_mode),
      .advance (rr_mode && !bcast_en),
      .gnt     (gnt)
   );

   always_comb begin
      sel_data = '0;
      and_data = '1;
      or_data  = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (gnt[i])      sel_data = sel_data | wr_data[i*WIDTH +: WIDTH];
         if (wr_valid[i]) begin
            and_data = and_data & wr_data[i*WIDTH +: WIDTH];
            or_data  = or_data  | wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      wr_ready = '0;
      q_d      = q_q;
      if (bcast_en) begin
         q_d = {WIDTH{bcast_val}};
      end else begin
         unique case (mode)
            MODE_PRIO, MODE_RR: wr_ready = gnt;
            default:            wr_ready = wr_valid;
         endcase
         if (|wr_valid) begin
            unique case (mode)
               MODE_AND: q_d = and_data;
               MODE_OR:  q_d = or_data;
               default:  q_d = sel_data;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q      <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         q_q <= q_d;
         if (clr_stat) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
         end else if (collision) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            sticky_q <= 1'b1;
         end
      end
   end

   assign q               = q_q;
   assign conflict_cnt    = cnt_q;
   assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_multi_writer_reg.sv
// Scoreboard bench for multi_writer_reg: directed steps queue expectations,
// a monitor pops and compares against a CNT_W=8 and a CNT_W=2 instance.
module tb_multi_writer_reg;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [1:0] wr_valid = 2'b00;
   logic [7:0] wr_data = 8'h00;
   logic       bcast_en = 1'b0;
   logic       bcast_val = 1'b0;
   logic       clr_stat = 1'b0;

   logic [1:0] wr_ready, wr_ready_s;
   logic [3:0] q, q_s;
   logic [7:0] cnt;
   logic [1:0] cnt_s;
   logic       sticky, sticky_s;

   always #5 clk = ~clk;

   multi_writer_reg #(
      .WIDTH (4),
      .N_SRC (2),
      .CNT_W (8)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mode            (mode),
      .wr_valid        (wr_valid),
      .wr_data         (wr_data),
      .wr_ready        (wr_ready),
      .bcast_en        (bcast_en),
      .bcast_val       (bcast_val),
      .clr_stat        (clr_stat),
      .q               (q),
      .conflict_cnt    (cnt),
      .conflict_sticky (sticky)
   );

   multi_writer_reg #(
      .WIDTH (4),
      .N_SRC (2),
      .CNT_W (2)
   ) dut_s (
      .clk             (clk),
      .rst_n           (rst_n),
      .mode            (mode),
      .wr_valid        (wr_valid),
      .wr_data         (wr_data),
      .wr_ready        (wr_ready_s),
      .bcast_en        (bcast_en),
      .bcast_val       (bcast_val),
      .clr_stat        (clr_stat),
      .q               (q_s),
      .conflict_cnt    (cnt_s),
      .conflict_sticky (sticky_s)
   );

   typedef struct {
      string      name;
      logic [1:0] rdy;
      logic [3:0] q;
      logic [7:0] cnt;
      logic       sticky;
      logic       now;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [1:0] sat2(input logic [7:0] c);
      return (c > 8'd3) ? 2'd3 : c[1:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; expectations cover this cycle's grant
   // and the state after the next rising edge.
   task automatic step(input string nm, input logic [1:0] m, input logic [1:0] v,
                       input logic [7:0] d, input logic be, input logic bv,
                       input logic cl, input logic [1:0] er, input logic [3:0] eq,
                       input logic [7:0] ec, input logic es);
      @(negedge clk);
      mode      = m;
      wr_valid  = v;
      wr_data   = d;
      bcast_en  = be;
      bcast_val = bv;
      clr_stat  = cl;
      sb.push_back('{name: nm, rdy: er, q: eq, cnt: ec, sticky: es, now: 1'b0});
   endtask

   task automatic expect_now(input string nm);
      sb.push_back('{name: nm, rdy: 2'b00, q: 4'h0, cnt: 8'd0, sticky: 1'b0, now: 1'b1});
   endtask

   initial begin
      exp_t it;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            it = sb.pop_front();
            chk({it.name, " wr_ready"}, 32'(wr_ready), 32'(it.rdy));
            chk({it.name, " wr_ready_s"}, 32'(wr_ready_s), 32'(it.rdy));
            if (!it.now) begin
               @(posedge clk);
               #1;
            end
            chk({it.name, " q"}, 32'(q), 32'(it.q));
            chk({it.name, " q_s"}, 32'(q_s), 32'(it.q));
            chk({it.name, " cnt"}, 32'(cnt), 32'(it.cnt));
            chk({it.name, " cnt_s"}, 32'(cnt_s), 32'(sat2(it.cnt)));
            chk({it.name, " sticky"}, 32'(sticky), 32'(it.sticky));
            chk({it.name, " sticky_s"}, 32'(sticky_s), 32'(it.sticky));
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_now("reset");

      //    name            md  valid  data   be  bv  clr  rdy    q     cnt st
      step("prio_both",     0, 2'b11, 8'h5A, 0, 0, 0, 2'b01, 4'hA, 1,  1);
      step("clr_idle",      0, 2'b00, 8'h00, 0, 0, 1, 2'b00, 4'hA, 0,  0);
      step("rr0",           1, 2'b11, 8'h21, 0, 0, 0, 2'b01, 4'h1, 1,  1);
      step("rr1",           1, 2'b11, 8'h21, 0, 0, 0, 2'b10, 4'h2, 2,  1);
      step("rr2",           1, 2'b11, 8'h21, 0, 0, 0, 2'b01, 4'h1, 3,  1);
      step("rr3",           1, 2'b11, 8'h21, 0, 0, 0, 2'b10, 4'h2, 4,  1);
      step("rr_single1",    1, 2'b10, 8'h71, 0, 0, 0, 2'b10, 4'h7, 4,  1);
      step("rr_single0",    1, 2'b01, 8'h03, 0, 0, 0, 2'b01, 4'h3, 4,  1);
      step("rr_idle",       1, 2'b00, 8'h00, 0, 0, 0, 2'b00, 4'h3, 4,  1);
      step("and_both",      2, 2'b11, 8'hAC, 0, 0, 0, 2'b11, 4'h8, 5,  1);
      step("or_both",       3, 2'b11, 8'hAC, 0, 0, 0, 2'b11, 4'hE, 6,  1);
      step("and_single",    2, 2'b01, 8'hAC, 0, 0, 0, 2'b01, 4'hC, 6,  1);
      step("bcast1",        3, 2'b11, 8'hAC, 1, 1, 0, 2'b00, 4'hF, 7,  1);
      step("bcast0",        3, 2'b11, 8'hAC, 1, 0, 0, 2'b00, 4'h0, 8,  1);
      step("bcast_rr",      1, 2'b11, 8'h21, 1, 1, 0, 2'b00, 4'hF, 9,  1);
      step("rr_after_bc",   1, 2'b11, 8'h21, 0, 0, 0, 2'b10, 4'h2, 10, 1);
      step("clr2",          0, 2'b00, 8'h00, 0, 0, 1, 2'b00, 4'h2, 0,  0);
      for (int i = 1; i <= 5; i++) begin
         step("sat", 0, 2'b11, 8'h5A, 0, 0, 0, 2'b01, 4'hA, 8'(i), 1);
      end
      step("clr_coll",      0, 2'b11, 8'h5A, 0, 0, 1, 2'b01, 4'hA, 0,  0);
      step("rr_pre",        1, 2'b11, 8'h21, 0, 0, 0, 2'b01, 4'h1, 1,  1);

      // Asynchronous reset between rising edges.
      @(negedge clk);
      rst_n    = 1'b0;
      wr_valid = 2'b00;
      expect_now("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("rr_post",       1, 2'b11, 8'h21, 0, 0, 0, 2'b01, 4'h1, 1,  1);
      @(negedge clk);
      wr_valid = 2'b00;

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_writer_reg.md
# multi_writer_reg

Parametrised shared register with N write sources and deterministic conflict resolution. Every source may request a write in any cycle. A run-time mode selects fixed-priority, round-robin, AND-merge or OR-merge resolution. A per-source grant tells each requester whether its write landed. A saturating counter and a sticky flag record multi-writer collisions, so software and benches can see contention that would otherwise stay silent. The block is instantiated wherever several control paths update one status/config register.

## Interface
- WIDTH, 4, data width of the shared register
- N_SRC, 2, number of write sources (≥2)
- CNT_W, 8, width of the collision counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  resolution: 0=PRIO (lowest index wins), 1=RR, 2=AND-merge, 3=OR-merge
- wr_valid  in  N_SRC  per-source write request
- wr_data  in  N_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- wr_ready  out  N_SRC  combinational grant; a write is accepted when wr_valid[i] and wr_ready[i] are both high
- bcast_en  in  1  broadcast override
- bcast_val  in  1  bit replicated to all WIDTH bits on broadcast
- clr_stat  in  1  synchronous clear of the collision statistics
- q  out  WIDTH  registered shared value
- conflict_cnt  out  CNT_W  saturating count of collision cycles
- conflict_sticky  out  1  set on first collision, held until clr_stat

## Operation
- Collision: a cycle with ≥2 wr_valid bits high, regardless of mode or bcast_en.
- PRIO mode: wr_ready is one-hot on the lowest-index valid source. q takes that source's data.
- RR mode: wr_ready is one-hot on the first valid source at or after rr_ptr, searching upward and wrapping from N_SRC-1 to 0. On a grant, rr_ptr becomes (granted index + 1) mod N_SRC. With no grant, rr_ptr holds. rr_ptr is retained in every mode but advances only in RR.
- AND / OR merge: wr_ready[i] = wr_valid[i]. q takes the bitwise AND / OR of all valid sources' data.
- No valid source and no broadcast: wr_ready = 0 and q holds.
- Broadcast has top priority. When bcast_en=1, q takes {WIDTH{bcast_val}}, all wr_ready are 0 and rr_ptr holds.
- Statistics:
  - On a collision, conflict_cnt increments and saturates at 2^CNT_W-1. conflict_sticky is set.
  - clr_stat has priority over a same-cycle collision: both counter and flag clear and that collision is not counted.
- mode is sampled every cycle. A change takes effect in the same cycle's grant with no flush.

## Timing
- Reset values: q=0, conflict_cnt=0, conflict_sticky=0, rr_ptr=0. wr_ready is then 0 until a valid arrives.
- wr_ready is a function of the current-cycle wr_valid, mode, bcast_en and rr_ptr. There are no registered paths from input to grant.
- Latency:
  - q reflects an accepted write one cycle after the accepting edge.
  - Statistics update on that same edge.
- Reset asserted mid-operation clears all state immediately (asynchronously). Writes in flight are dropped. The first write after deassertion behaves as if from reset state (RR starts at source 0).
- The counter at saturation with a further collision stays at its maximum and the flag stays 1.

## Structure
- Shared package multi_writer_pkg holds:
  - the mode encoding constants MODE_PRIO, MODE_RR, MODE_AND, MODE_OR
  - a WIDTH-independent helper function returning the index of the first set bit from a start position with wrap-around
- One sub-module, rr_arbiter (parameter N). Inputs: req, advance enable. Outputs: one-hot gnt. It owns rr_ptr. It serves PRIO by forcing its start position to 0.
- Merge logic, the broadcast mux, the q register and the statistics counter live in the top module.

## Test plan
- Reset, PRIO, WIDTH=4, N_SRC=2:
  - After reset, q=0, cnt=0 and sticky=0.
  - Drive both valids with data0=4'hA and data1=4'h5.
  - Required: wr_ready=2'b01, q=4'hA next cycle, cnt=1, sticky=1.
- RR fairness: hold both valids for 4 cycles with data0=4'h1 and data1=4'h2.
  - Grants alternate 01,10,01,10.
  - q sequence is 1,2,1,2.
  - cnt=4.
- Merge modes: both valids with data0=4'b1100 and data1=4'b1010.
  - mode=2 → q=4'b1000.
  - mode=3 → q=4'b1110.
  - wr_ready=2'b11 in both.
- Broadcast override: bcast_en=1, bcast_val=1, both valids high.
  - Required: q=4'hF, wr_ready=0, cnt still increments.
  - Then bcast_val=0 → q=4'h0.
- Statistics boundaries, CNT_W=2:
  - 5 collision cycles → cnt saturates at 3.
  - clr_stat together with a collision → cnt=0 and sticky=0.
- Async reset mid-burst in RR after source 0 was granted: assert rst_n=0 between edges.
  - Required: q=0 and cnt=0 immediately.
  - The first post-reset dual request grants source 0.
